// File: rtl/dz_matrix_scan.sv
// Double-buffered red/green dot-matrix scanner with frame-synchronous swap,
// per-slot anti-ghost blanking and hardware blink. Outputs are registered from next-state.
module dz_matrix_scan #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int SCAN_DIV     = 1,
  parameter int BLANK_CYC    = 0,
  parameter int BLINK_FRAMES = 64,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_r,
  input  logic [COLS-1:0] wr_g,
  input  logic            swap_req,
  input  logic            blink_en,
  output logic            swap_ack,
  output logic            frame_start,
  output logic [ROWS-1:0] row,
  output logic [COLS-1:0] colr,
  output logic [COLS-1:0] colg
);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic [COLS-1:0] r;
    logic [COLS-1:0] g;
  } pix_t;

  pix_t [1:0][ROWS-1:0] buf_q;
  logic                 run_q;
  logic [SW-1:0]        slot_q, slot_d;
  logic [RW-1:0]        ridx_q, ridx_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic                 phase_q, phase_d, fsel_q, fsel_d, pend_q, pend_d;
  logic                 boundary, swap_now, wr_ok, blank, blank_slot;
  pix_t                 front_pix;
  logic [ROWS-1:0]      row_d, row_q;
  logic [COLS-1:0]      colr_q, colg_q;
  logic                 ack_q, fs_q;

  // Counters hold the position being displayed; the first cycle after reset
  // holds them at (0,0) so cycle 1 shows row 0.
  always_comb begin
    slot_d   = slot_q;
    ridx_d   = ridx_q;
    bcnt_d   = bcnt_q;
    phase_d  = phase_q;
    boundary = run_q && (slot_q == SLOT_LAST) && (ridx_q == ROW_LAST);
    if (run_q) begin
      if (slot_q == SLOT_LAST) begin
        slot_d = '0;
        ridx_d = (ridx_q == ROW_LAST) ? '0 : ridx_q + 1'b1;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
    if (boundary) begin
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
    swap_now = boundary && (pend_q || swap_req);
    fsel_d   = fsel_q ^ swap_now;
    pend_d   = swap_now ? 1'b0 : (pend_q || swap_req);
    wr_ok    = wr_en && (32'(wr_row) < ROWS);
    // A write landing on the swap edge targets the new front; forward it.
    front_pix = buf_q[fsel_d][ridx_d];
    if (wr_ok && swap_now && (wr_row == ridx_d))
      front_pix = '{r: wr_r, g: wr_g};
    row_d         = '1;
    row_d[ridx_d] = 1'b0;
    blank         = blank_slot || (blink_en && phase_d);
  end

  generate
    if (BLANK_CYC > 0) begin : g_blank
      assign blank_slot = (32'(slot_d) < BLANK_CYC);
    end else begin : g_noblank
      assign blank_slot = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q   <= '0;
      run_q   <= 1'b0;
      slot_q  <= '0;
      ridx_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      fsel_q  <= 1'b0;
      pend_q  <= 1'b0;
      row_q   <= '1;
      colr_q  <= '0;
      colg_q  <= '0;
      ack_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      slot_q  <= slot_d;
      ridx_q  <= ridx_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      fsel_q  <= fsel_d;
      pend_q  <= pend_d;
      if (wr_ok)
        buf_q[~fsel_q][wr_row] <= '{r: wr_r, g: wr_g};
      row_q  <= row_d;
      colr_q <= blank ? '0 : front_pix.r;
      colg_q <= blank ? '0 : front_pix.g;
      ack_q  <= swap_now;
      fs_q   <= (slot_d == '0) && (ridx_d == '0);
    end
  end

  assign row         = row_q;
  assign colr        = colr_q;
  assign colg        = colg_q;
  assign swap_ack    = ack_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_dz_matrix_scan.sv
// Directed bench for dz_matrix_scan: default scan/swap/reset, blanking,
// blink and out-of-range/boundary writes on four parameterisations.
module tb_dz_matrix_scan;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0, swap_req = 1'b0, blink_en = 1'b0;
  logic [2:0] wr_row = '0;
  logic [7:0] wr_r = '0, wr_g = '0;

  logic       ack0, fs0, ack1, fs1, ack2, fs2, ack3, fs3;
  logic [7:0] row0, cr0, cg0, row1, cr1, cg1, row2, cr2, cg2, cr3, cg3;
  logic [5:0] row3;

  int ncmp = 0, nerr = 0;

  always #5 clk = ~clk;

  dz_matrix_scan u0 (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_r(wr_r),
    .wr_g(wr_g), .swap_req(swap_req), .blink_en(blink_en), .swap_ack(ack0),
    .frame_start(fs0), .row(row0), .colr(cr0), .colg(cg0));
  dz_matrix_scan #(.SCAN_DIV(4), .BLANK_CYC(1)) u1 (.clk(clk), .rst(rst), .wr_en(wr_en),
    .wr_row(wr_row), .wr_r(wr_r), .wr_g(wr_g), .swap_req(swap_req), .blink_en(blink_en),
    .swap_ack(ack1), .frame_start(fs1), .row(row1), .colr(cr1), .colg(cg1));
  dz_matrix_scan #(.BLINK_FRAMES(2)) u2 (.clk(clk), .rst(rst), .wr_en(wr_en),
    .wr_row(wr_row), .wr_r(wr_r), .wr_g(wr_g), .swap_req(swap_req), .blink_en(blink_en),
    .swap_ack(ack2), .frame_start(fs2), .row(row2), .colr(cr2), .colg(cg2));
  dz_matrix_scan #(.ROWS(6)) u3 (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row),
    .wr_r(wr_r), .wr_g(wr_g), .swap_req(swap_req), .blink_en(blink_en),
    .swap_ack(ack3), .frame_start(fs3), .row(row3), .colr(cr3), .colg(cg3));

  typedef struct {
    logic       wr;
    logic       sreq;
    logic [7:0] row;
    logic       fs;
    logic       ack;
    logic [7:0] col;
  } vec_t;
  vec_t tbl [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Leaves rst deasserted mid-cycle; the next tick is cycle 1.
  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; swap_req = 1'b0; blink_en = 1'b0;
    wr_row = '0; wr_r = '0; wr_g = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 8'hFE, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 8'hFD, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 8'hFB, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 1'b1, 8'hF7, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 1'b0, 8'hEF, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 1'b0, 8'hDF, 1'b0, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 1'b0, 8'hBF, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 1'b0, 8'hFE, 1'b1, 1'b1, 8'h00};
    tbl[9]  = '{1'b0, 1'b0, 8'hFD, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 1'b0, 8'hFB, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 1'b0, 8'hF7, 1'b0, 1'b0, 8'h3C};

    // Reset state and default scan/swap table
    tick(); #1;
    chk("rst_row", row0, 8'hFF);
    chk("rst_colr", cr0, 8'h00);
    chk("rst_colg", cg0, 8'h00);
    chk("rst_fs", fs0, 1'b0);
    chk("rst_ack", ack0, 1'b0);
    chk("rst_row6", row3, 6'h3F);
    do_reset();
    wr_row = 3'd3; wr_r = 8'h3C; wr_g = 8'h3C;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("tbl%0d_row", k + 1), row0, tbl[k].row);
      chk($sformatf("tbl%0d_fs", k + 1), fs0, tbl[k].fs);
      chk($sformatf("tbl%0d_ack", k + 1), ack0, tbl[k].ack);
      chk($sformatf("tbl%0d_colr", k + 1), cr0, tbl[k].col);
      chk($sformatf("tbl%0d_colg", k + 1), cg0, tbl[k].col);
      wr_en = tbl[k].wr;
      swap_req = tbl[k].sreq;
    end

    // Asynchronous reset while row F7 is displayed
    #2 rst = 1'b1;
    #1;
    chk("async_row", row0, 8'hFF);
    chk("async_colr", cr0, 8'h00);
    chk("async_colg", cg0, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    chk("rerun_row", row0, 8'hFE);
    chk("rerun_fs", fs0, 1'b1);
    tick(); tick(); tick();
    chk("rerun_row4", row0, 8'hF7);
    chk("rerun_col4", cr0, 8'h00);

    // Blanking: SCAN_DIV=4, BLANK_CYC=1
    do_reset();
    tick();
    wr_en = 1'b1; wr_row = 3'd0; wr_r = 8'hFF; wr_g = 8'h00; swap_req = 1'b1;
    tick();
    wr_en = 1'b0; swap_req = 1'b0;
    for (int c = 3; c <= 33; c++) tick();
    chk("blk_ack", ack1, 1'b1);
    chk("blk_fs", fs1, 1'b1);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("blk_row_s%0d", s), row1, 8'hFE);
      chk($sformatf("blk_colr_s%0d", s), cr1, (s == 0) ? 8'h00 : 8'hFF);
      chk($sformatf("blk_colg_s%0d", s), cg1, 8'h00);
      tick();
    end
    chk("blk_row_next", row1, 8'hFD);
    chk("blk_colr_next", cr1, 8'h00);

    // Blink: BLINK_FRAMES=2, fill all rows during frame 0 and swap at its end
    do_reset();
    blink_en = 1'b1;
    for (int r = 0; r < 8; r++) begin
      tick();
      wr_en = 1'b1; wr_row = 3'(r); wr_r = 8'hFF; wr_g = 8'hFF;
      swap_req = (r == 0);
    end
    tick();
    wr_en = 1'b0; swap_req = 1'b0;
    for (int f = 1; f <= 5; f++) begin
      for (int r = 0; r < 8; r++) begin
        logic [7:0] er, ec;
        er = 8'hFF; er[r] = 1'b0;
        ec = (f == 2 || f == 3) ? 8'h00 : 8'hFF;
        chk($sformatf("blink_f%0d_r%0d_row", f, r), row2, er);
        chk($sformatf("blink_f%0d_r%0d_colr", f, r), cr2, ec);
        chk($sformatf("blink_f%0d_r%0d_colg", f, r), cg2, ec);
        tick();
      end
    end

    // ROWS=6: out-of-range write, write+swap in the boundary cycle
    do_reset();
    tick();
    wr_en = 1'b1; wr_row = 3'd7; wr_r = 8'hAA; wr_g = 8'h55;
    tick();
    wr_en = 1'b0;
    for (int c = 3; c <= 6; c++) tick();
    chk("e6_row_bnd", row3, 6'h1F);
    wr_en = 1'b1; wr_row = 3'd0; wr_r = 8'h81; wr_g = 8'h42; swap_req = 1'b1;
    tick();
    wr_en = 1'b0; swap_req = 1'b0;
    chk("e6_ack", ack3, 1'b1);
    chk("e6_fs", fs3, 1'b1);
    chk("e6_row0", row3, 6'h3E);
    chk("e6_colr0", cr3, 8'h81);
    chk("e6_colg0", cg3, 8'h42);
    for (int r = 1; r < 6; r++) begin
      tick();
      chk($sformatf("e6_ack_r%0d", r), ack3, 1'b0);
      chk($sformatf("e6_colr_r%0d", r), cr3, 8'h00);
      chk($sformatf("e6_colg_r%0d", r), cg3, 8'h00);
    end
    tick();
    chk("e6_next_fs", fs3, 1'b1);
    chk("e6_next_ack", ack3, 1'b0);
    chk("e6_next_colr", cr3, 8'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
